// File: rtl/osd_dii_vc_bridge_if.sv
// DII flit stream between the regaccess layer and the bridge.
// Forward: valid, last, 16-bit data. Backward: ready.
interface osd_dii_vc_bridge_if;
    logic        valid;
    logic        last;
    logic [15:0] data;
    logic        ready;

    modport master (output valid, last, data, input ready);
    modport slave  (input valid, last, data, output ready);
endinterface

// File: rtl/osd_dii_vc_bridge.sv
// DII <-> virtual-channel bridge.
// Ingress: a three-flit staging buffer captures the packet header, picks the
// VC from flit 2, then drains into that VC's show-ahead FIFO and streams the
// rest of the packet straight through.
// Egress: packet-atomic round-robin merge of NUM_VC streams into one
// registered DII output.
module osd_dii_vc_bridge #(
    parameter int NUM_VC = 2,
    parameter int DEPTH  = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    osd_dii_vc_bridge_if.slave       dii_in,
    osd_dii_vc_bridge_if.master      dii_out,
    output logic [NUM_VC*16-1:0]     vc_out_data,
    output logic [NUM_VC-1:0]        vc_out_last,
    output logic [NUM_VC-1:0]        vc_out_valid,
    input  logic [NUM_VC-1:0]        vc_out_ready,
    input  logic [NUM_VC*16-1:0]     vc_in_data,
    input  logic [NUM_VC-1:0]        vc_in_last,
    input  logic [NUM_VC-1:0]        vc_in_valid,
    output logic [NUM_VC-1:0]        vc_in_ready
);
    localparam int VCW = $clog2(NUM_VC);
    localparam int AW  = $clog2(DEPTH);
    localparam int PW  = AW + 1;

    typedef enum logic [1:0] {ST_HDR, ST_DRAIN, ST_STREAM} ing_state_e;

    typedef struct packed {
        logic        last;
        logic [15:0] data;
    } flit_t;

    // ------------------------------------------------------------------
    // Ingress staging / routing
    // ------------------------------------------------------------------
    ing_state_e     state, state_nxt;
    logic [1:0]     idx, idx_nxt;       // HDR: next free slot; DRAIN: slot being pushed
    logic [1:0]     cnt, cnt_nxt;       // number of staged flits (1..3)
    logic           ended, ended_nxt;   // staged flits already contain the last flit
    logic [VCW-1:0] vc, vc_nxt;
    logic           stage_we;
    flit_t          stage [3];

    logic [NUM_VC-1:0] full;
    logic [NUM_VC-1:0] empty;
    logic [NUM_VC-1:0] push;
    logic [NUM_VC-1:0] pop;
    flit_t             push_flit;

    // Ingress next-state, ready and FIFO push selection.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        state_nxt    = state;
        idx_nxt      = idx;
        cnt_nxt      = cnt;
        ended_nxt    = ended;
        vc_nxt       = vc;
        stage_we     = 1'b0;
        push         = '0;
        push_flit    = stage[idx];
        dii_in.ready = 1'b0;

        unique case (state)
            ST_HDR: begin
                dii_in.ready = 1'b1;
                if (dii_in.valid) begin
                    stage_we = 1'b1;
                    if (dii_in.last || idx == 2'd2) begin
                        state_nxt = ST_DRAIN;
                        cnt_nxt   = idx + 2'd1;
                        ended_nxt = dii_in.last;
                        idx_nxt   = 2'd0;
                        // Short packets carry no type_sub field and default to VC0.
                        vc_nxt    = (idx == 2'd2) ? dii_in.data[10 +: VCW] : '0;
                    end else begin
                        idx_nxt = idx + 2'd1;
                    end
                end
            end

            ST_DRAIN: begin
                push_flit = stage[idx];
                if (!full[vc]) begin
                    push[vc] = 1'b1;
                    if (idx == cnt - 2'd1) begin
                        state_nxt = ended ? ST_HDR : ST_STREAM;
                        idx_nxt   = 2'd0;
                    end else begin
                        idx_nxt = idx + 2'd1;
                    end
                end
            end

            ST_STREAM: begin
                dii_in.ready = !full[vc];
                push_flit    = '{last: dii_in.last, data: dii_in.data};
                if (dii_in.valid && !full[vc]) begin
                    push[vc] = 1'b1;
                    if (dii_in.last) begin
                        state_nxt = ST_HDR;
                    end
                end
            end

            default: state_nxt = ST_HDR;
        endcase
    end

    // Ingress control registers.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: non-blocking assignments so every flop updates from pre-edge values.
        if (!rst_n) begin
            state <= ST_HDR;
            idx   <= 2'd0;
            cnt   <= 2'd0;
            ended <= 1'b0;
            vc    <= '0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
            cnt   <= cnt_nxt;
            ended <= ended_nxt;
            vc    <= vc_nxt;
        end
    end

    // Staging buffer capture of header flits.
    always_ff @(posedge clk) begin
        if (stage_we) begin
            stage[idx] <= '{last: dii_in.last, data: dii_in.data};
        end
    end

    // ------------------------------------------------------------------
    // Per-VC show-ahead FIFOs
    // ------------------------------------------------------------------
    for (genvar v = 0; v < NUM_VC; v++) begin : g_fifo
        flit_t         mem [DEPTH];
        logic [PW-1:0] wr_ptr;
        logic [PW-1:0] rd_ptr;

        assign empty[v] = (wr_ptr == rd_ptr);
        assign full[v]  = (wr_ptr[AW] != rd_ptr[AW]) &&
                          (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
        assign pop[v]   = !empty[v] && vc_out_ready[v];

        assign vc_out_valid[v]         = !empty[v];
        assign vc_out_data[v*16 +: 16] = mem[rd_ptr[AW-1:0]].data;
        assign vc_out_last[v]          = mem[rd_ptr[AW-1:0]].last;

        // FIFO storage write.
        always_ff @(posedge clk) begin
            // NOTE: storage is not reset; the pointers alone define what is valid.
            if (push[v]) begin
                mem[wr_ptr[AW-1:0]] <= push_flit;
            end
        end

        // FIFO pointers; the extra MSB distinguishes full from empty.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push[v]) wr_ptr <= wr_ptr + PW'(1);
                if (pop[v])  rd_ptr <= rd_ptr + PW'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Egress round-robin merge
    // ------------------------------------------------------------------
    logic [VCW-1:0]    rr;
    logic [VCW-1:0]    grant;
    logic              grant_valid;
    logic              out_free;
    logic              xfer;
    logic              xfer_last;
    logic [NUM_VC-1:0] other_req;
    logic [VCW-1:0]    next_start;

    // First requester at or after start, cyclically.
    function automatic logic [VCW-1:0] pick(input logic [NUM_VC-1:0] req,
                                            input logic [VCW-1:0]    start);
        logic [VCW-1:0] c;
        pick = start;
        for (int i = NUM_VC - 1; i >= 0; i--) begin
            c = start + VCW'(i);
            if (req[c]) pick = c;
        end
    endfunction

    assign out_free   = !dii_out.valid || dii_out.ready;
    assign xfer       = grant_valid && vc_in_valid[grant] && out_free;
    assign xfer_last  = xfer && vc_in_last[grant];
    assign next_start = grant + VCW'(1);

    // Per-VC accept and the requesters eligible for the look-ahead grant.
    always_comb begin
        vc_in_ready = '0;
        other_req   = vc_in_valid;
        if (grant_valid) begin
            vc_in_ready[grant] = out_free;
        end
        other_req[grant] = 1'b0;
    end

    // Grant tracking. On a packet's last flit the next grant is chosen in the
    // same edge, so a waiting VC streams with no idle cycle in between.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr          <= '0;
            grant       <= '0;
            grant_valid <= 1'b0;
        end else if (!grant_valid) begin
            if (|vc_in_valid) begin
                grant       <= pick(vc_in_valid, rr);
                grant_valid <= 1'b1;
            end
        end else if (xfer_last) begin
            rr <= next_start;
            if (|other_req) begin
                grant <= pick(other_req, next_start);
            end else begin
                grant_valid <= 1'b0;
            end
        end
    end

    // Registered DII output stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dii_out.valid <= 1'b0;
            dii_out.last  <= 1'b0;
            dii_out.data  <= '0;
        end else if (xfer) begin
            dii_out.valid <= 1'b1;
            dii_out.last  <= vc_in_last[grant];
            dii_out.data  <= vc_in_data[grant*16 +: 16];
        end else if (dii_out.ready) begin
            dii_out.valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_osd_dii_vc_bridge.sv
// Self-checking bench for osd_dii_vc_bridge (NUM_VC=2, DEPTH=4).
// Ingress: packets are queued with their expected VC (flit 2 type_sub low
// bits, or VC0 for packets of one or two flits); each VC sink compares what it
// pops. Egress: each source tags its flits with its VC; the sink checks
// per-VC order, exactly-once delivery, no interleaving and stall stability.
module tb_osd_dii_vc_bridge;
    localparam int NV = 2;
    localparam int DP = 4;
    localparam int VB = $clog2(NV);

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    osd_dii_vc_bridge_if dii_in_if ();
    osd_dii_vc_bridge_if dii_out_if ();

    logic [NV*16-1:0] vc_out_data;
    logic [NV-1:0]    vc_out_last;
    logic [NV-1:0]    vc_out_valid;
    logic [NV-1:0]    vc_out_ready;
    logic [NV*16-1:0] vc_in_data;
    logic [NV-1:0]    vc_in_last;
    logic [NV-1:0]    vc_in_valid;
    logic [NV-1:0]    vc_in_ready;

    osd_dii_vc_bridge #(.NUM_VC(NV), .DEPTH(DP)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .dii_in       (dii_in_if),
        .dii_out      (dii_out_if),
        .vc_out_data  (vc_out_data),
        .vc_out_last  (vc_out_last),
        .vc_out_valid (vc_out_valid),
        .vc_out_ready (vc_out_ready),
        .vc_in_data   (vc_in_data),
        .vc_in_last   (vc_in_last),
        .vc_in_valid  (vc_in_valid),
        .vc_in_ready  (vc_in_ready)
    );

    int tests = 0;
    int fails = 0;

    logic [16:0] in_q [$];
    logic [16:0] exp_vc [NV][$];
    logic [16:0] src_q [NV][$];
    logic [16:0] exp_out [NV][$];
    int          pkt_order [$];
    int          cur_vc = -1;
    bit          stall_pend = 1'b0;
    logic [16:0] held;
    bit          in_hold = 1'b0;
    int          in_rate = 100, pop_rate = 100, src_rate = 100, out_rate = 100;
    bit          out_toggle = 1'b0;
    int          rdy_low, accepted, seq = 0;
    bit          vc0_seen;
    logic [NV-1:0] last_vcv;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int pending();
        int n = in_q.size();
        for (int v = 0; v < NV; v++) n += exp_vc[v].size() + exp_out[v].size();
        return n;
    endfunction

    task automatic add_in_pkt(input logic [15:0] d[$]);
        int vc = 0;
        if (d.size() > 2) vc = int'(d[2] >> 10) % NV;
        for (int i = 0; i < d.size(); i++) begin
            in_q.push_back({i == d.size() - 1, d[i]});
            exp_vc[vc].push_back({i == d.size() - 1, d[i]});
        end
    endtask

    task automatic rand_pkt(input int len, input int vc_sel);
        logic [15:0] d[$];
        logic [15:0] t;
        for (int i = 0; i < len; i++) d.push_back(16'($urandom));
        if (len > 2 && vc_sel >= 0) begin
            t = d[2];
            t[10 +: VB] = VB'(vc_sel);
            d[2] = t;
        end
        add_in_pkt(d);
    endtask

    task automatic add_eg_pkt(input int v, input int len);
        logic [16:0] f;
        for (int i = 0; i < len; i++) begin
            seq++;
            f = {i == len - 1, v[3:0], seq[11:0]};
            src_q[v].push_back(f);
            exp_out[v].push_back(f);
        end
    endtask

    task automatic score_out();
        int v;
        v = int'(dii_out_if.data[15:12]);
        if (cur_vc >= 0) check("dii_out_no_interleave", v, cur_vc);
        if (v >= NV) begin
            check("dii_out_bad_tag", {15'd0, dii_out_if.last, dii_out_if.data}, 32'hffff_ffff);
        end else if (exp_out[v].size() == 0) begin
            check("dii_out_unexpected", {15'd0, dii_out_if.last, dii_out_if.data}, 32'hffff_ffff);
        end else begin
            check("dii_out_flit", {15'd0, dii_out_if.last, dii_out_if.data},
                  {15'd0, exp_out[v].pop_front()});
        end
        if (dii_out_if.last) begin
            cur_vc = -1;
            pkt_order.push_back(v);
        end else begin
            cur_vc = v;
        end
    endtask

    // One clock: sample and score at negedge, drive new inputs just after posedge.
    task automatic cycle();
        logic [16:0] f;
        @(negedge clk);
        last_vcv = vc_out_valid;
        if (!dii_in_if.ready) rdy_low++;
        if (vc_out_valid[0]) vc0_seen = 1'b1;
        in_hold = dii_in_if.valid && !dii_in_if.ready;
        if (dii_in_if.valid && dii_in_if.ready) begin
            accepted++;
            void'(in_q.pop_front());
        end
        for (int v = 0; v < NV; v++) begin
            if (vc_out_valid[v] && vc_out_ready[v]) begin
                if (exp_vc[v].size() == 0)
                    check($sformatf("vc_out%0d_unexpected", v),
                          {15'd0, vc_out_last[v], vc_out_data[v*16 +: 16]}, 32'hffff_ffff);
                else
                    check($sformatf("vc_out%0d_flit", v),
                          {15'd0, vc_out_last[v], vc_out_data[v*16 +: 16]},
                          {15'd0, exp_vc[v].pop_front()});
            end
        end
        for (int v = 0; v < NV; v++) begin
            if (vc_in_valid[v] && vc_in_ready[v]) void'(src_q[v].pop_front());
        end
        if (stall_pend)
            check("dii_out_hold", {14'd0, dii_out_if.valid, dii_out_if.last, dii_out_if.data},
                  {14'd0, 1'b1, held});
        stall_pend = 1'b0;
        if (dii_out_if.valid) begin
            if (dii_out_if.ready) begin
                score_out();
            end else begin
                stall_pend = 1'b1;
                held = {dii_out_if.last, dii_out_if.data};
            end
        end

        @(posedge clk);
        #1;
        if (in_q.size() > 0 && (in_hold || $urandom_range(99) < in_rate)) begin
            f = in_q[0];
            dii_in_if.valid = 1'b1;
            dii_in_if.last  = f[16];
            dii_in_if.data  = f[15:0];
        end else begin
            dii_in_if.valid = 1'b0;
            dii_in_if.last  = 1'b0;
            dii_in_if.data  = 16'($urandom);
        end
        for (int v = 0; v < NV; v++) begin
            vc_out_ready[v] = ($urandom_range(99) < pop_rate);
            // A valid source keeps offering the same flit until it is taken.
            if (src_q[v].size() > 0 && (vc_in_valid[v] || $urandom_range(99) < src_rate)) begin
                f = src_q[v][0];
                vc_in_valid[v]          = 1'b1;
                vc_in_last[v]           = f[16];
                vc_in_data[v*16 +: 16]  = f[15:0];
            end else begin
                vc_in_valid[v] = 1'b0;
                vc_in_last[v]  = 1'b0;
            end
        end
        if (out_toggle) dii_out_if.ready = ~dii_out_if.ready;
        else            dii_out_if.ready = ($urandom_range(99) < out_rate);
    endtask

    task automatic drain(input int budget, output int used);
        used = 0;
        while (pending() != 0 && used < budget) begin
            cycle();
            used++;
        end
        check("drain_timeout", pending(), 0);
    endtask

    task automatic clear_model();
        in_q.delete();
        for (int v = 0; v < NV; v++) begin
            exp_vc[v].delete();
            src_q[v].delete();
            exp_out[v].delete();
        end
        cur_vc     = -1;
        stall_pend = 1'b0;
        in_hold    = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        rst_n            = 1'b1;
        dii_in_if.valid  = 1'b0;
        dii_in_if.last   = 1'b0;
        dii_in_if.data   = '0;
        dii_out_if.ready = 1'b1;
        vc_out_ready     = '0;
        vc_in_valid      = '1;
        vc_in_last       = '0;
        vc_in_data       = '0;

        // Step 1: reset values (sources already requesting, yet no grant).
        #2 rst_n = 1'b0;
        #10;
        check("rst_dii_in_ready", dii_in_if.ready, 1);
        check("rst_dii_out_valid", dii_out_if.valid, 0);
        check("rst_dii_out_data", {dii_out_if.last, dii_out_if.data}, 0);
        check("rst_vc_out_valid", vc_out_valid, 0);
        check("rst_vc_in_ready", vc_in_ready, 0);
        vc_in_valid = '0;
        @(negedge clk);
        rst_n = 1'b1;
        cycle();

        // Step 2: 4-flit packet to VC1, check latency and 3-cycle DRAIN stall.
        rdy_low = 0; vc0_seen = 1'b0;
        rand_pkt(4, 1);
        n = 0;
        while (in_q.size() > 1 && n < 50) begin cycle(); n++; end
        cycle();
        check("lat_vc1_before", last_vcv[1], 0);
        cycle();
        check("lat_vc1_after", last_vcv[1], 1);
        drain(100, n);
        check("drain_ready_low_cycles", rdy_low, 3);
        check("vc0_untouched", vc0_seen, 0);

        // Step 3: short packet goes to VC0 even though flit 1 has bit 10 set.
        begin
            logic [15:0] d[$];
            d.push_back(16'hAAAA);
            d.push_back(16'h5555);
            add_in_pkt(d);
        end
        drain(100, n);
        check("short_back_to_hdr", dii_in_if.ready, 1);

        // Step 4: backpressure with DEPTH=4 on VC1.
        pop_rate = 0; accepted = 0;
        rand_pkt(8, 1);
        repeat (20) cycle();
        check("bp_accepted", accepted, 4);
        check("bp_ready_low", dii_in_if.ready, 0);
        check("bp_vc1_valid", vc_out_valid[1], 1);
        pop_rate = 100;
        drain(100, n);

        // Step 5: random ingress traffic with random sink backpressure.
        in_rate = 60; pop_rate = 50;
        repeat (30) rand_pkt($urandom_range(1, 9), -1);
        drain(3000, n);
        in_rate = 100; pop_rate = 100;

        // Step 6: two always-valid egress sources alternate packet by packet.
        src_rate = 100; out_rate = 100;
        pkt_order.delete();
        for (int k = 0; k < 4; k++) begin
            add_eg_pkt(0, 3);
            add_eg_pkt(1, 3);
        end
        drain(200, n);
        check("eg_pkt_count", pkt_order.size(), 8);
        for (int i = 0; i < pkt_order.size(); i++)
            check($sformatf("eg_rr_order%0d", i), pkt_order[i], i % 2);
        check("eg_no_idle", n <= 28, 1);

        // Step 7: dii_out_ready toggling every cycle.
        out_toggle = 1'b1;
        add_eg_pkt(1, 5);
        add_eg_pkt(0, 4);
        drain(200, n);
        out_toggle = 1'b0;

        // Step 8: mixed random ingress and egress.
        in_rate = 70; pop_rate = 70; src_rate = 50; out_rate = 60;
        repeat (20) rand_pkt($urandom_range(1, 8), -1);
        repeat (16) add_eg_pkt($urandom_range(0, NV - 1), $urandom_range(1, 6));
        drain(4000, n);

        // Step 9: reset in the middle of a streamed packet and a stalled egress flit.
        in_rate = 100; pop_rate = 100; src_rate = 100; out_rate = 0;
        accepted = 0;
        add_eg_pkt(0, 4);
        rand_pkt(8, 1);
        n = 0;
        while (accepted < 5 && n < 40) begin cycle(); n++; end
        check("mid_stream_reached", accepted, 5);
        rst_n = 1'b0;
        #1;
        check("mid_rst_dii_in_ready", dii_in_if.ready, 1);
        check("mid_rst_vc_out_valid", vc_out_valid, 0);
        check("mid_rst_dii_out", {dii_out_if.valid, dii_out_if.last, dii_out_if.data}, 0);
        check("mid_rst_vc_in_ready", vc_in_ready, 0);
        clear_model();
        dii_in_if.valid  = 1'b0;
        vc_in_valid      = '0;
        dii_out_if.ready = 1'b1;
        out_rate = 100;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        rand_pkt(3, 1);
        drain(100, n);
        check("post_rst_hdr", dii_in_if.ready, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
